// File: rtl/instr_loader.sv
`default_nettype none
// =============================================================================
// instr_loader : packs received UART bytes MSB-first into instructions and
//                writes them to consecutive instruction-memory words from 0.
// Revision 1.0
// =============================================================================
module instr_loader #(
  parameter int unsigned    LEN       = 32,
  parameter int unsigned    LEN_UART  = 8,
  parameter int unsigned    CANT_INST = 64,
  parameter logic [LEN-1:0] HALT_INST = 32'hFFFFFFFF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_rx_done,
  input  logic [LEN_UART-1:0]            i_uart_data,
  output logic                           o_wr_en,
  output logic [$clog2(CANT_INST)-1:0]   o_wr_addr,
  output logic [LEN-1:0]                 o_wr_data,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_overflow,
  output logic [$clog2(CANT_INST):0]     o_inst_count
);

  localparam int unsigned NB  = LEN / LEN_UART;
  localparam int unsigned AW  = $clog2(CANT_INST);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [BCW-1:0] BC_LAST   = BCW'(NB - 1);
  localparam logic [BCW-1:0] BC_ONE    = BCW'(1);
  localparam logic [AW-1:0]  ADDR_LAST = AW'(CANT_INST - 1);
  localparam logic [CW-1:0]  COUNT_MAX = CW'(CANT_INST);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t          state_q,   state_d;
  logic [BCW-1:0]  bc_q,      bc_d;
  logic [LEN-1:0]  shreg_q,   shreg_d;
  logic [AW-1:0]   addr_q,    addr_d;
  logic [CW-1:0]   count_q,   count_d;
  logic            wr_en_q,   wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [LEN-1:0]  wr_data_q, wr_data_d;

  logic [LEN-1:0]  shifted;

  generate
    if (NB > 1) begin : g_shift_multi
      assign shifted = {shreg_q[LEN-LEN_UART-1:0], i_uart_data};
    end else begin : g_shift_single
      assign shifted = i_uart_data;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // A byte arriving together with start is dropped.
        if (i_start) begin
          state_d = ST_RECV;
          addr_d  = '0;
          bc_d    = '0;
          count_d = '0;
          shreg_d = '0;
        end
      end

      ST_RECV: begin
        if (i_rx_done) begin
          shreg_d = shifted;
          if (bc_q == BC_LAST) begin
            bc_d      = '0;
            state_d   = ST_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = shifted;
          end else begin
            bc_d = bc_q + BC_ONE;
          end
        end
      end

      ST_WRITE: begin
        if (count_q != COUNT_MAX) begin
          count_d = count_q + CW'(1);
        end
        if (shreg_q == HALT_INST) begin
          state_d = ST_DONE;
        end else if (addr_q == ADDR_LAST) begin
          state_d = ST_ERROR;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = ST_RECV;
          // A byte landing in the write cycle starts the next word.
          if (i_rx_done) begin
            shreg_d = shifted;
            if (bc_q == BC_LAST) begin
              state_d   = ST_WRITE;
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q + AW'(1);
              wr_data_d = shifted;
            end else begin
              bc_d = BC_ONE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bc_q      <= '0;
      shreg_q   <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bc_q      <= bc_d;
      shreg_q   <= shreg_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign o_done       = (state_q == ST_DONE);
  assign o_overflow   = (state_q == ST_ERROR);
  assign o_inst_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// =============================================================================
// tb_instr_loader : directed self-checking bench for instr_loader.
// Revision 1.0
// =============================================================================
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a;
  logic       start_b;
  logic       rx_done;
  logic [7:0] uart_data;

  always #5 clk = ~clk;

  logic        wr_en_a, busy_a, done_a, ovf_a;
  logic [5:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [6:0]  count_a;

  logic        wr_en_b, busy_b, done_b, ovf_b;
  logic [1:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [2:0]  count_b;

  instr_loader u_dut_a (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start_a),
    .i_rx_done    (rx_done),
    .i_uart_data  (uart_data),
    .o_wr_en      (wr_en_a),
    .o_wr_addr    (wr_addr_a),
    .o_wr_data    (wr_data_a),
    .o_busy       (busy_a),
    .o_done       (done_a),
    .o_overflow   (ovf_a),
    .o_inst_count (count_a)
  );

  instr_loader #(.CANT_INST(4)) u_dut_b (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start_b),
    .i_rx_done    (rx_done),
    .i_uart_data  (uart_data),
    .o_wr_en      (wr_en_b),
    .o_wr_addr    (wr_addr_b),
    .o_wr_data    (wr_data_b),
    .o_busy       (busy_b),
    .o_done       (done_b),
    .o_overflow   (ovf_b),
    .o_inst_count (count_b)
  );

  // Write logs captured on the falling edge.
  logic [5:0]  log_a_addr[$];
  logic [31:0] log_a_data[$];
  logic [1:0]  log_b_addr[$];
  logic [31:0] log_b_data[$];

  always @(negedge clk) begin
    if (wr_en_a === 1'b1) begin
      log_a_addr.push_back(wr_addr_a);
      log_a_data.push_back(wr_data_a);
    end
    if (wr_en_b === 1'b1) begin
      log_b_addr.push_back(wr_addr_b);
      log_b_data.push_back(wr_data_b);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done   = 1'b1;
    uart_data = b;
    tick();
    rx_done   = 1'b0;
  endtask

  task automatic send_word_gap(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      tick();
    end
  endtask

  task automatic send_word_b2b(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  task automatic check_log_a(input string tag, input int base,
                             input logic [31:0] exp_data[$]);
    check({tag, "_nwr"}, 64'(log_a_data.size() - base), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++) begin
      if (base + i < log_a_data.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(log_a_addr[base+i]), 64'(i));
        check($sformatf("%s_data%0d", tag, i), 64'(log_a_data[base+i]), 64'(exp_data[i]));
      end
    end
  endtask

  initial begin
    int base_a;
    int base_b;
    logic [31:0] exp_q[$];

    rst       = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    rx_done   = 1'b0;
    uart_data = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_wr_en",   64'(wr_en_a),   64'd0);
    check("rst_busy",    64'(busy_a),    64'd0);
    check("rst_done",    64'(done_a),    64'd0);
    check("rst_ovf",     64'(ovf_a),     64'd0);
    check("rst_count",   64'(count_a),   64'd0);
    check("rst_wr_addr", 64'(wr_addr_a), 64'd0);
    check("rst_wr_data", 64'(wr_data_a), 64'd0);
    rst = 1'b0;
    tick();

    // Bytes in IDLE are ignored
    base_a = log_a_data.size();
    send_word_b2b(32'h12345678);
    repeat (2) tick();
    check("idle_nwr",  64'(log_a_data.size() - base_a), 64'd0);
    check("idle_busy", 64'(busy_a), 64'd0);

    // Start collides with a byte: byte dropped, then a basic 3-word load
    base_a    = log_a_data.size();
    start_a   = 1'b1;
    rx_done   = 1'b1;
    uart_data = 8'hEE;
    tick();
    start_a   = 1'b0;
    rx_done   = 1'b0;
    check("start_busy", 64'(busy_a), 64'd1);
    send_word_gap(32'h20080005);
    send_word_gap(32'h20090007);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hFF);
      tick();
    end
    send_byte(8'hFF);
    check("lat_wr_en",   64'(wr_en_a),   64'd1);
    check("lat_wr_addr", 64'(wr_addr_a), 64'd2);
    check("lat_wr_data", 64'(wr_data_a), 64'hFFFFFFFF);
    repeat (2) tick();
    check("basic_done",  64'(done_a),    64'd1);
    check("basic_ovf",   64'(ovf_a),     64'd0);
    check("basic_busy",  64'(busy_a),    64'd0);
    check("basic_count", 64'(count_a),   64'd3);
    check("hold_wr_en",  64'(wr_en_a),   64'd0);
    check("hold_addr",   64'(wr_addr_a), 64'd2);
    check("hold_data",   64'(wr_data_a), 64'hFFFFFFFF);
    exp_q = '{32'h20080005, 32'h20090007, 32'hFFFFFFFF};
    check_log_a("basic", base_a, exp_q);

    // Restart with 1 word + HALT, bytes back-to-back
    base_a = log_a_data.size();
    pulse_start_a();
    check("restart_done",  64'(done_a),  64'd0);
    check("restart_busy",  64'(busy_a),  64'd1);
    check("restart_count", 64'(count_a), 64'd0);
    send_word_b2b(32'hCAFEBABE);
    send_word_b2b(32'hFFFFFFFF);
    repeat (3) tick();
    check("restart_fin_done", 64'(done_a),  64'd1);
    check("restart_fin_cnt",  64'(count_a), 64'd2);
    exp_q = '{32'hCAFEBABE, 32'hFFFFFFFF};
    check_log_a("restart", base_a, exp_q);

    // Longer back-to-back stream, byte every cycle including WRITE cycles
    base_a = log_a_data.size();
    pulse_start_a();
    send_word_b2b(32'h01234567);
    send_word_b2b(32'h89ABCDEF);
    send_word_b2b(32'h0F1E2D3C);
    send_word_b2b(32'hFFFFFFFF);
    repeat (3) tick();
    check("b2b_done",  64'(done_a),  64'd1);
    check("b2b_count", 64'(count_a), 64'd4);
    exp_q = '{32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'hFFFFFFFF};
    check_log_a("b2b", base_a, exp_q);

    // Mid-word reset discards the partial word
    pulse_start_a();
    send_byte(8'hAA);
    tick();
    send_byte(8'hBB);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy",  64'(busy_a),  64'd0);
    check("midrst_count", 64'(count_a), 64'd0);
    check("midrst_done",  64'(done_a),  64'd0);
    base_a = log_a_data.size();
    pulse_start_a();
    send_word_gap(32'h11223344);
    send_word_gap(32'hFFFFFFFF);
    repeat (2) tick();
    check("midrst_fin_done", 64'(done_a), 64'd1);
    exp_q = '{32'h11223344, 32'hFFFFFFFF};
    check_log_a("midrst", base_a, exp_q);

    // Overflow on the 4-word instance; A sits in DONE and must ignore bytes
    base_a = log_a_data.size();
    base_b = log_b_data.size();
    pulse_start_b();
    for (int i = 1; i <= 4; i++) begin
      send_word_gap(32'(i));
    end
    repeat (2) tick();
    check("ovf_flag",  64'(ovf_b),   64'd1);
    check("ovf_busy",  64'(busy_b),  64'd0);
    check("ovf_done",  64'(done_b),  64'd0);
    check("ovf_count", 64'(count_b), 64'd4);
    check("ovf_nwr",   64'(log_b_data.size() - base_b), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (base_b + i < log_b_data.size()) begin
        check($sformatf("ovf_addr%0d", i), 64'(log_b_addr[base_b+i]), 64'(i));
        check($sformatf("ovf_data%0d", i), 64'(log_b_data[base_b+i]), 64'(i + 1));
      end
    end
    base_b = log_b_data.size();
    send_word_b2b(32'h00000005);
    send_word_b2b(32'hFFFFFFFF);
    repeat (3) tick();
    check("ovf_ignore_nwr",  64'(log_b_data.size() - base_b), 64'd0);
    check("ovf_still_flag",  64'(ovf_b), 64'd1);
    check("done_ignore_nwr", 64'(log_a_data.size() - base_a), 64'd0);

    // Restart from ERROR
    base_b = log_b_data.size();
    pulse_start_b();
    check("ovf_clr",  64'(ovf_b),  64'd0);
    check("ovf_rbusy", 64'(busy_b), 64'd1);
    send_word_gap(32'hFFFFFFFF);
    repeat (2) tick();
    check("ovf_r_done",  64'(done_b),  64'd1);
    check("ovf_r_count", 64'(count_b), 64'd1);
    check("ovf_r_nwr",   64'(log_b_data.size() - base_b), 64'd1);
    if (base_b < log_b_data.size()) begin
      check("ovf_r_addr", 64'(log_b_addr[base_b]), 64'd0);
      check("ovf_r_data", 64'(log_b_data[base_b]), 64'hFFFFFFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
